// File: rtl/demux_1nto4n_buf_pkg.sv
// Shared lane count, lane-select encoding and select decode for the 1:4 result demux.
// Optional broadcast mode is enabled by defining DEMUX_BROADCAST_EN.
package demux_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_sel_t;

    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_sel_t sel);
        logic [NUM_LANES-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_1nto4n_buf_if.sv
// Producer/consumer bundle of the 1:4 demux: one handshaked input word, four handshaked lanes.
// The bc signal exists only when DEMUX_BROADCAST_EN is defined.
interface demux_1nto4n_buf_if #(
    parameter int N = 32
);
    logic [N-1:0] I;
    logic [1:0]   S;
    logic         en;
    logic         in_valid;
    logic         in_ready;
`ifdef DEMUX_BROADCAST_EN
    logic         bc;
`endif
    logic [N-1:0] O0, O1, O2, O3;
    logic         valid0, valid1, valid2, valid3;
    logic         ready0, ready1, ready2, ready3;

    // Driven by the producer and the four consumers
    modport master (
        output I, S, en, in_valid,
`ifdef DEMUX_BROADCAST_EN
        output bc,
`endif
        output ready0, ready1, ready2, ready3,
        input  in_ready,
        input  O0, O1, O2, O3,
        input  valid0, valid1, valid2, valid3
    );

    modport slave (
        input  I, S, en, in_valid,
`ifdef DEMUX_BROADCAST_EN
        input  bc,
`endif
        input  ready0, ready1, ready2, ready3,
        output in_ready,
        output O0, O1, O2, O3,
        output valid0, valid1, valid2, valid3
    );

endinterface

// File: rtl/demux_1nto4n_buf_lane_buf.sv
// One-entry lane holding buffer: loads on load, empties when the consumer takes the word.
// Output reads zero whenever the slot is empty.
module demux_lane_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         free
);

    logic [N-1:0] data_p1;
    logic         vld_p1;

    // A word leaving this edge frees the slot for a word arriving at the same edge
    assign free  = !vld_p1 || drain;
    assign valid = vld_p1;
    assign q     = vld_p1 ? data_p1 : '0;

    // Stage p1: lane holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            data_p1 <= d;
            vld_p1  <= 1'b1;
        end else if (drain && vld_p1) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1nto4n_buf.sv
// Registered 1:4 demultiplexer with valid/ready handshake and a one-entry buffer per lane.
// Defining DEMUX_BROADCAST_EN adds bc, which loads the input word into all four lanes at once.
module demux_1nto4n_buf
    import demux_pkg::*;
#(
    parameter int N = 32
) (
    input logic              clk,
    input logic              rst,
    demux_1nto4n_buf_if.slave bus
);

    logic [NUM_LANES-1:0] lane_free;
    logic [NUM_LANES-1:0] lane_vld;
    logic [NUM_LANES-1:0] lane_rdy;
    logic [NUM_LANES-1:0] sel_oh;
    logic [NUM_LANES-1:0] lane_load;
    logic [N-1:0]         lane_q [NUM_LANES];
    logic                 bc_mode;
    logic                 in_ready_c;
    logic                 accept;

`ifdef DEMUX_BROADCAST_EN
    assign bc_mode = bus.bc;
`else
    assign bc_mode = 1'b0;
`endif

    assign lane_rdy = {bus.ready3, bus.ready2, bus.ready1, bus.ready0};

    // Broadcast needs every lane free; unicast only the selected one.
    // Held low through reset so nothing is taken while the buffers are being cleared.
    always_comb begin
        sel_oh     = lane_onehot(lane_sel_t'(bus.S));
        in_ready_c = 1'b0;
        if (rst && bus.en) begin
            if (bc_mode) begin
                in_ready_c = &lane_free;
            end else begin
                in_ready_c = |(lane_free & sel_oh);
            end
        end
        accept    = bus.in_valid && in_ready_c;
        lane_load = '0;
        if (accept) begin
            lane_load = bc_mode ? '1 : sel_oh;
        end
    end

    assign bus.in_ready = in_ready_c;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane_buf #(
            .N(N)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (lane_load[k]),
            .drain(lane_rdy[k]),
            .d    (bus.I),
            .q    (lane_q[k]),
            .valid(lane_vld[k]),
            .free (lane_free[k])
        );
    end

    assign bus.O0     = lane_q[0];
    assign bus.O1     = lane_q[1];
    assign bus.O2     = lane_q[2];
    assign bus.O3     = lane_q[3];
    assign bus.valid0 = lane_vld[0];
    assign bus.valid1 = lane_vld[1];
    assign bus.valid2 = lane_vld[2];
    assign bus.valid3 = lane_vld[3];

endmodule

// File: doc/demux_1nto4n_buf.md
Name: demux_1Nto4N_buf

Overview:
- Registered 1:4 demultiplexer with valid/ready handshake. It is the write-side counterpart of the 4:1 operand mux.
- Routes one N-bit word to one of four destination lanes selected by S. Each lane has a one-entry holding buffer so producer and consumers decouple by one cycle.
- Sits on the pipelined processor's result/forwarding path, fanning one source out to four consumers.

Parameters:
N, 32, data width in bits of input word and of each output lane.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
I  input  N  input data word.
S  input  2  destination lane select (0..3).
en  input  1  block enable; 0 blocks new accepts.
in_valid  input  1  producer has a valid word on I.
in_ready  output  1  block accepts I this cycle.
O0..O3  output  N each  lane data.
valid0..valid3  output  1 each  lane holds a valid word.
ready0..ready3  input  1 each  consumer takes the lane word this cycle.

Behaviour:
- Reset (rst=0, asynchronous): all lane buffers empty; valid0..3=0; O0..O3=0. in_ready=0 while rst=0.
- Lane k "free" = !validk || readyk; a same-cycle drain frees the slot.
- in_ready = en && free[S], combinational.
- Accept = in_valid && in_ready, at the rising clk edge.
  - On accept: lane S register <= I, validS <= 1.
  - Latency: data is visible on O[S] and validS the cycle after accept.
- Drain: validk && readyk at the edge with no accept to lane k -> validk <= 0, Ok <= 0.
- Simultaneous drain and accept on the same lane: new word loads, validk stays 1. Full throughput is 1 word/cycle per lane.
- Ok drives 0 whenever validk=0, consistent with the mux's zero-when-disabled output.
- en=0 blocks new accepts only; held words keep driving and drain normally.
- Changing S while in_valid=1 and in_ready=0 is legal. The producer holds I until accepted; there is no internal ordering between lanes.
- readyk asserted while validk=0: ignored.
- Reset asserted mid-transfer: buffers clear immediately and the pending word is dropped. The producer must re-send after reset.
- Lanes are independent; no cross-lane stalls except through the shared in_ready.

Optional Feature:
- Macro DEMUX_BROADCAST_EN.
- Defined:
  - Extra input port bc (1 bit).
  - When bc=1, in_ready = en && all four lanes free. An accept loads I into all four lanes and sets valid0..3=1. S is ignored.
  - When bc=0, behaviour is as above.
- Undefined: no bc port; unicast only. Behaviour is identical to defined-with-bc=0.

Decomposition:
- Package demux_pkg: localparam NUM_LANES=4; typedef enum logic [1:0] lane_sel_t {LANE0, LANE1, LANE2, LANE3}.
- Sub-module demux_lane_buf, instantiated four times. It is a one-entry buffer with:
  - inputs clk, rst, load, drain, d[N-1:0];
  - outputs q (zero when empty), valid, free.
- Top level contains only select decode, in_ready logic and the broadcast option.

Test Plan:
- Reset: rst=0 while in_valid=1 -> valid0..3=0, O0..O3=0, in_ready=0. Release rst -> state unchanged until first accept.
- Unicast: en=1, ready0..3=0, send 32'hE59F1020 with S=0, then 32'h28A44EAF (S=1), 32'h122225A8 (S=2), 32'h500A9D49 (S=3). Required:
  - each word appears on the matching Ok one cycle after its accept;
  - all valid=1 after the fourth accept;
  - other lanes are untouched.
- Backpressure: lane 2 full and ready2=0, S=2, in_valid=1 -> in_ready=0 and O2 holds 32'h122225A8. Raise ready2 -> in_ready=1 the same cycle, and the new word replaces O2 next cycle with valid2 still 1.
- Enable: en=0 with all lanes empty and in_valid=1 for 5 cycles -> no accepts, valid0..3=0. A held lane-1 word still drains when ready1=1, after which O1=0.
- Back-to-back: S=3, ready3=1 constantly, 8 consecutive words -> 8 accepts in 8 cycles and O3 tracks each word with 1-cycle lag.
- Broadcast (DEMUX_BROADCAST_EN): bc=1, I=32'hA5A5A5A5 with lane 0 full -> in_ready=0. Drain lane 0 -> all four lanes load 32'hA5A5A5A5 with valid0..3=1.
